ex_div: RTL and testbench

- Multi-cycle 32-bit radix-2 restoring divider for the EX stage.
- Consumes the div/divu operands and control that the decode stage sends on id_to_ex_bus: div_divu, stop_div_mul, and rdata1/rdata2.
- Asserts a stall request to the stall controller while a division is in flight.
- Returns {remainder, quotient} for the HI/LO write.

---
 rtl/ex_div.sv | 148 ++++++++++++++
 tb/tb_ex_div.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// ex_div: multi-cycle 32-bit radix-2 restoring divider for the EX stage (div/divu -> {hi=rem, lo=quo}).
// Build option DIV_EARLY_OUT_EN: answer in one cycle when |dividend| < |divisor|.
module ex_div #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        annul_i,
  input  logic        hold_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0]     r_rem, r_quo, r_dvs;
  logic [W-1:0]     w_rem_nxt, w_quo_nxt, w_dvs_nxt;
  logic             r_qneg, r_rneg, w_qneg_nxt, w_rneg_nxt;
  logic [2*W-1:0]   r_result, w_result_nxt;
  logic             r_ready, w_ready_nxt;

  logic             w_capture, w_div_zero, w_early, w_last;
  logic [W-1:0]     w_dend_mag, w_dvs_mag;
  logic [W:0]       w_rem_sh, w_trial;
  logic [W-1:0]     w_rem_step, w_quo_step, w_quo_fix, w_rem_fix;

  // Operand magnitudes as seen at capture
  assign w_capture  = start_i & ~annul_i;
  assign w_div_zero = (divisor_i == '0);
  assign w_dend_mag = (signed_i & dividend_i[W-1]) ? W'(-dividend_i) : dividend_i;
  assign w_dvs_mag  = (signed_i & divisor_i[W-1])  ? W'(-divisor_i)  : divisor_i;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = ~w_div_zero & (w_dend_mag < w_dvs_mag);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step; the bit shifted out of rem is kept so divisors above 2^31 stay exact
  assign w_last     = (r_cnt == CNT_W'(ITER - 1));
  assign w_rem_sh   = {r_rem, r_quo[W-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_dvs};
  assign w_rem_step = w_trial[W] ? w_rem_sh[W-1:0] : w_trial[W-1:0];
  assign w_quo_step = {r_quo[W-2:0], ~w_trial[W]};
  assign w_quo_fix  = r_qneg ? W'(-w_quo_step) : w_quo_step;
  assign w_rem_fix  = r_rneg ? W'(-w_rem_step) : w_rem_step;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; annul wins over everything but reset
  always_comb begin
    w_state_nxt = r_state;
    if (annul_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (w_div_zero)   w_state_nxt = S_DIVZERO;
            else if (w_early) w_state_nxt = S_END;
            else              w_state_nxt = S_ON;
          end
        end
        S_DIVZERO: w_state_nxt = S_END;
        S_ON:      if (w_last) w_state_nxt = S_END;
        S_END:     if (!hold_i) w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_dvs_nxt    = r_dvs;
    w_qneg_nxt   = r_qneg;
    w_rneg_nxt   = r_rneg;
    w_result_nxt = r_result;
    w_ready_nxt  = (w_state_nxt == S_END);
    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          w_cnt_nxt  = '0;
          w_rem_nxt  = '0;
          w_quo_nxt  = w_dend_mag;
          w_dvs_nxt  = w_dvs_mag;
          w_qneg_nxt = signed_i & (dividend_i[W-1] ^ divisor_i[W-1]);
          w_rneg_nxt = signed_i & dividend_i[W-1];
          if (w_early) w_result_nxt = {dividend_i, {W{1'b0}}};
        end
      end
      S_ON: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_rem_nxt = w_rem_step;
        w_quo_nxt = w_quo_step;
        if (w_last && !annul_i) w_result_nxt = {w_rem_fix, w_quo_fix};
      end
      S_DIVZERO: begin
        if (!annul_i) w_result_nxt = '0;
      end
      default: ;
    endcase
  end

  // Working and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_dvs    <= w_dvs_nxt;
      r_qneg   <= w_qneg_nxt;
      r_rneg   <= w_rneg_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = start_i & ~r_ready;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: table-driven and scoreboard-checked bench for ex_div (honours DIV_EARLY_OUT_EN for latency).
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic        hold_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  ex_div dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .dividend_i(dividend_i),
    .divisor_i (divisor_i),
    .annul_i   (annul_i),
    .hold_i    (hold_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } sb_t;

  sb_t         sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] last_res = '0;

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

  // Reference: unsigned divide of magnitudes, then sign fix-up with 32-bit wrap
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    if (b == 32'd0) return 64'd0;
    ma = mag(sgn, a);
    mb = mag(sgn, b);
    q  = ma / mb;
    r  = ma % mb;
    if (sgn && (a[31] ^ b[31])) q = ~q + 32'd1;
    if (sgn && a[31])           r = ~r + 32'd1;
    return {r, q};
  endfunction

  function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (mag(sgn, a) < mag(sgn, b)) return 1;
`endif
    return 33;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
    sb_t e;
    e.res = exp;
    e.lat = ref_lat(sgn, a, b);
    sb_q.push_back(e);
  endtask

  // Called at the C0 negedge with inputs already driven; returns at negedge+1 of the first ready cycle
  task automatic wait_result();
    int  cyc    = 0;
    int  stalls = 0;
    sb_t e;
    forever begin
      #1;
      if (ready_o) break;
      if (stallreq_o) stalls++;
      if (cyc == 80) begin
        n_vec++;
        n_err++;
        $display("FAIL timeout: ready_o still 0 after %0d cycles, want 1", cyc);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        return;
      end
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        dividend_i = $urandom;
        divisor_i  = $urandom;
      end
    end
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_result: got %h, want none", result_o);
      return;
    end
    e = sb_q.pop_front();
    chk("result", result_o, e.res);
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("stall_cycles", 64'(stalls), 64'(e.lat));
    last_res = e.res;
  endtask

  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    annul_i    = 1'b0;
    hold_i     = 1'b0;
    push_exp(sgn, a, b, exp);
    wait_result();
    start_i = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_ready", 64'(ready_o), 64'd0);
    chk("idle_stall", 64'(stallreq_o), 64'd0);
  endtask

  vec_t tbl[10];

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    logic        saw_ready;

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; dividend_i = '0; divisor_i = '0;
    annul_i = 1'b0; hold_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;

    tbl[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E};
    tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002, 64'hFFFFFFFF_FFFFFFFD};
    tbl[2] = '{1'b1, 32'h00000007,   32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    tbl[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000};
    tbl[4] = '{1'b0, 32'hFFFFFFFF,   32'h00000000, 64'h00000000_00000000};
    tbl[5] = '{1'b0, 32'd3,          32'd10,       64'h00000003_00000000};
    tbl[6] = '{1'b1, 32'hFFFFFFFD,   32'd10,       64'hFFFFFFFD_00000000};
    tbl[7] = '{1'b0, 32'hFFFFFFFF,   32'h80000001, 64'h7FFFFFFE_00000001};
    tbl[8] = '{1'b0, 32'hFFFFFFFF,   32'h00000001, 64'h00000000_FFFFFFFF};
    tbl[9] = '{1'b1, 32'h80000000,   32'h00000002, 64'h00000000_C0000000};
    for (int i = 0; i < 10; i++) do_div(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp);

    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 30);
      if (i == 2) ra = rb >> 1;
      do_div(rs, ra, rb, ref_div(rs, ra, rb));
    end

    // Annul at C10 of divu 1000/3: no result, result_o keeps its previous value
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i   = 1'b0;
    saw_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ready_o) saw_ready = 1'b1;
      @(negedge clk);
    end
    chk("annul_no_ready", 64'(saw_ready), 64'd0);
    chk("annul_result_kept", result_o, last_res);
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // Hold in END for 4 cycles, then back-to-back divu 8/2 straight from IDLE
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd5;
    push_exp(1'b0, 32'd50, 32'd5, 64'h00000000_0000000A);
    wait_result();
    hold_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, 64'h00000000_0000000A);
      chk("hold_stall", 64'(stallreq_o), 64'd0);
    end
    @(negedge clk);
    #1;
    chk("hold_last_ready", 64'(ready_o), 64'd1);
    hold_i     = 1'b0;
    dividend_i = 32'd8;
    divisor_i  = 32'd2;
    push_exp(1'b0, 32'd8, 32'd2, 64'h00000000_00000004);
    @(negedge clk);
    wait_result();
    start_i = 1'b0;

    // Reset in the middle of a division clears the result
    @(negedge clk);
    start_i = 1'b1; dividend_i = 32'd123; divisor_i = 32'd4;
    repeat (5) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_ready", 64'(ready_o), 64'd0);
    chk("midrst_result", result_o, 64'd0);
    rst = 1'b0;

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
